// File: rtl/sr_flop_bank.sv
// Bank of independent clocked SR flops with sticky illegal (S=R=1) flags.
// Optional saturating illegal-event counter: define SR_FLOP_BANK_ILLEGAL_CNT_EN.
module sr_flop_bank #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] illegal,
`ifdef SR_FLOP_BANK_ILLEGAL_CNT_EN
  output logic             illegal_any,
  output logic [CNT_W-1:0] illegal_cnt
`else
  output logic             illegal_any
`endif
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_ill;
  logic [WIDTH-1:0] w_both;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_nxt;

  // Catch out-of-range parameters at elaboration.
  if (WIDTH < 1 || WIDTH > 32 || CNT_W < 1 || MODE < 0 || MODE > 3)
  begin : g_bad_param
    $error("sr_flop_bank: parameter out of range");
  end

  // S=R=1 resolution, fixed per instance.
  if (MODE == 0) begin : g_rst_dom
    assign w_res = '0;
  end else if (MODE == 1) begin : g_set_dom
    assign w_res = '1;
  end else if (MODE == 3) begin : g_toggle
    assign w_res = ~r_q;
  end else begin : g_hold
    assign w_res = r_q;
  end

  assign w_both = s & r;

  // Per-channel next state from the s/r pair.
  always_comb begin
    w_nxt = r_q;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({s[i], r[i]})
        2'b00: w_nxt[i] = r_q[i];
        2'b01: w_nxt[i] = 1'b0;
        2'b10: w_nxt[i] = 1'b1;
        2'b11: w_nxt[i] = w_res[i];
      endcase
    end
  end

  // Channel state and sticky illegal flags; clr beats s/r.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q   <= '0;
      r_ill <= '0;
    end else if (clr) begin
      r_q   <= '0;
      r_ill <= '0;
    end else begin
      r_q   <= w_nxt;
      r_ill <= r_ill | w_both;
    end
  end

  assign q           = r_q;
  assign q_bar       = ~r_q;
  assign illegal     = r_ill;
  assign illegal_any = |r_ill;

`ifdef SR_FLOP_BANK_ILLEGAL_CNT_EN
  // Sum is wide enough for CNT_W-bit count plus a 32-channel popcount.
  localparam int SW = (CNT_W > 6 ? CNT_W : 6) + 1;

  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       w_pop;
  logic [SW-1:0]    w_sum;
  logic [SW-1:0]    w_max;

  // Number of channels seeing s=r=1 this cycle.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + 6'(w_both[i]);
    end
  end

  assign w_max = SW'({CNT_W{1'b1}});
  assign w_sum = SW'(r_cnt) + SW'(w_pop);

  // Saturating accumulate of illegal events.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (w_sum > w_max) begin
      r_cnt <= {CNT_W{1'b1}};
    end else begin
      r_cnt <= w_sum[CNT_W-1:0];
    end
  end

  assign illegal_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_sr_flop_bank.sv
// Directed bench for sr_flop_bank: four MODE instances plus a CNT_W=4 one,
// all sharing the same stimulus.
module tb_sr_flop_bank;

  logic       clk;
  logic       reset_n;
  logic [7:0] s;
  logic [7:0] r;
  logic       clr;

  logic [7:0] q0, qb0, il0, q1, qb1, il1;
  logic [7:0] q2, qb2, il2, q3, qb3, il3;
  logic [7:0] q4, qb4, il4;
  logic       any0, any1, any2, any3, any4;
`ifdef SR_FLOP_BANK_ILLEGAL_CNT_EN
  logic [7:0] cnt0, cnt1, cnt2, cnt3;
  logic [3:0] cnt4;
`endif

  int n_chk;
  int n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SR_FLOP_BANK_ILLEGAL_CNT_EN
  `define CNTP(x) , .illegal_cnt(x)
`else
  `define CNTP(x)
`endif

  sr_flop_bank #(.WIDTH(8), .MODE(0), .CNT_W(8)) u0 (
    .clk(clk), .reset_n(reset_n), .s(s), .r(r), .clr(clr),
    .q(q0), .q_bar(qb0), .illegal(il0), .illegal_any(any0) `CNTP(cnt0));
  sr_flop_bank #(.WIDTH(8), .MODE(1), .CNT_W(8)) u1 (
    .clk(clk), .reset_n(reset_n), .s(s), .r(r), .clr(clr),
    .q(q1), .q_bar(qb1), .illegal(il1), .illegal_any(any1) `CNTP(cnt1));
  sr_flop_bank #(.WIDTH(8), .MODE(2), .CNT_W(8)) u2 (
    .clk(clk), .reset_n(reset_n), .s(s), .r(r), .clr(clr),
    .q(q2), .q_bar(qb2), .illegal(il2), .illegal_any(any2) `CNTP(cnt2));
  sr_flop_bank #(.WIDTH(8), .MODE(3), .CNT_W(8)) u3 (
    .clk(clk), .reset_n(reset_n), .s(s), .r(r), .clr(clr),
    .q(q3), .q_bar(qb3), .illegal(il3), .illegal_any(any3) `CNTP(cnt3));
  sr_flop_bank #(.WIDTH(8), .MODE(0), .CNT_W(4)) u4 (
    .clk(clk), .reset_n(reset_n), .s(s), .r(r), .clr(clr),
    .q(q4), .q_bar(qb4), .illegal(il4), .illegal_any(any4) `CNTP(cnt4));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    reset_n = 1'b0;
    s       = '0;
    r       = '0;
    clr     = 1'b0;
    #3;
    chk("rst_q", 32'(q0), 32'h00);
    chk("rst_qbar", 32'(qb0), 32'hFF);
    chk("rst_ill", 32'(il0), 32'h00);
    chk("rst_any", 32'(any0), 32'h0);
`ifdef SR_FLOP_BANK_ILLEGAL_CNT_EN
    chk("rst_cnt", 32'(cnt0), 32'h0);
`endif
    step();
    reset_n = 1'b1;

    // Basic set and hold
    step();
    s = 8'h0F;
    step();
    s = 8'h00;
    chk("set_q", 32'(q0), 32'h0F);
    chk("set_qbar", 32'(qb0), 32'hF0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_q", 32'(q0), 32'h0F);
    end
    chk("hold_qbar", 32'(qb0), 32'hF0);
    chk("hold_ill", 32'(il0), 32'h00);

    // Independent set on ch7, reset on ch0..3
    s = 8'h80;
    r = 8'h0F;
    step();
    s = 8'h00;
    r = 8'h00;
    chk("indep_q", 32'(q0), 32'h80);
    chk("indep_ill", 32'(il0), 32'h00);

    // Mode resolution from q[0]=0
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_q", 32'(q0), 32'h00);
    s = 8'h01;
    r = 8'h01;
    step();
    s = 8'h00;
    r = 8'h00;
    chk("m0_q", 32'(q0), 32'h00);
    chk("m1_q", 32'(q1), 32'h01);
    chk("m2_q", 32'(q2), 32'h00);
    chk("m3_q", 32'(q3), 32'h01);
    chk("m3_qbar", 32'(qb3), 32'hFE);
    chk("m0_ill", 32'(il0), 32'h01);
    chk("m1_ill", 32'(il1), 32'h01);
    chk("m2_ill", 32'(il2), 32'h01);
    chk("m3_ill", 32'(il3), 32'h01);
    chk("m0_any", 32'(any0), 32'h1);
    step();
    chk("sticky_ill", 32'(il2), 32'h01);

    // Toggle for four cycles
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_ill", 32'(il3), 32'h00);
    s = 8'h01;
    r = 8'h01;
    step();
    chk("tog1", 32'(q3), 32'h01);
    step();
    chk("tog2", 32'(q3), 32'h00);
    step();
    chk("tog3", 32'(q3), 32'h01);
    step();
    chk("tog4", 32'(q3), 32'h00);
    s = 8'h00;
    r = 8'h00;
    chk("tog_ill", 32'(il3), 32'h01);
`ifdef SR_FLOP_BANK_ILLEGAL_CNT_EN
    chk("tog_cnt", 32'(cnt3), 32'd4);
`endif

    // Saturation on the 4-bit counter
    clr = 1'b1;
    step();
    clr = 1'b0;
    s = 8'hFF;
    r = 8'hFF;
    step();
    chk("sat_ill", 32'(il4), 32'hFF);
`ifdef SR_FLOP_BANK_ILLEGAL_CNT_EN
    chk("sat1", 32'(cnt4), 32'd8);
    step();
    chk("sat2", 32'(cnt4), 32'd15);
    step();
    chk("sat3", 32'(cnt4), 32'd15);
    s = 8'h00;
    r = 8'h00;
    step();
    chk("sat4", 32'(cnt4), 32'd15);
`endif

    // clr overrides s=r=1
    s = 8'hFF;
    r = 8'hFF;
    clr = 1'b1;
    step();
    clr = 1'b0;
    s = 8'h00;
    r = 8'h00;
    chk("clrp_q", 32'(q1), 32'h00);
    chk("clrp_ill", 32'(il0), 32'h00);
    chk("clrp_any", 32'(any0), 32'h0);
`ifdef SR_FLOP_BANK_ILLEGAL_CNT_EN
    chk("clrp_cnt", 32'(cnt4), 32'd0);
    chk("clrp_cnt8", 32'(cnt3), 32'd0);
`endif

    // Asynchronous reset between edges
    s = 8'hAA;
    step();
    s = 8'h00;
    chk("pre_rst_q", 32'(q0), 32'hAA);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_q", 32'(q0), 32'h00);
    chk("arst_qbar", 32'(qb0), 32'hFF);
    #1;
    reset_n = 1'b1;
    s = 8'h0F;
    step();
    s = 8'h00;
    chk("post_rst_q", 32'(q0), 32'h0F);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
